// File: rtl/audio_echo.sv
// Stereo feed-forward echo: out = in + (in delayed DEPTH accepted samples) >>> SHIFT, saturated.
// One sample pair in flight; two synchronous-read delay RAMs share one write pointer.
module audio_echo #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 4800,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned SHIFT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right
);

  typedef enum logic [1:0] {StIdle, StRd, StMix, StOut} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              filled_q;
  logic [DATA_W-1:0] cap_l_q, cap_r_q;
  logic [DATA_W-1:0] rd_l_q, rd_r_q;
  logic [DATA_W-1:0] mem_l [DEPTH];
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] mix_l, mix_r;
  logic              ptr_last;

  assign ptr_last = (wr_ptr_q == ADDR_W'(DEPTH - 1));

  // Add the attenuated delayed sample at DATA_W+1 bits and clamp to the signed range.
  function automatic logic [DATA_W-1:0] echo_mix(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] q,
                                                 input logic              use_q);
    logic signed [DATA_W-1:0] d;
    logic signed [DATA_W-1:0] e;
    logic signed [DATA_W:0]   s;
    d = use_q ? q : '0;
    e = d >>> SHIFT;
    s = {x[DATA_W-1], x} + {e[DATA_W-1], e};
    if (s[DATA_W] != s[DATA_W-1]) begin
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    return s[DATA_W-1:0];
  endfunction

  always_comb begin
    mix_l = cap_l_q;
    mix_r = cap_r_q;
    if (enable) begin
      mix_l = echo_mix(cap_l_q, rd_l_q, filled_q);
      mix_r = echo_mix(cap_r_q, rd_r_q, filled_q);
    end
  end

  // Read always targets wr_ptr, so the value seen in MIX predates this sample's own write.
  always_ff @(posedge clk) begin
    if (state_q == StMix) begin
      mem_l[wr_ptr_q] <= cap_l_q;
      mem_r[wr_ptr_q] <= cap_r_q;
    end
    rd_l_q <= mem_l[wr_ptr_q];
    rd_r_q <= mem_r[wr_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      filled_q  <= 1'b0;
      cap_l_q   <= '0;
      cap_r_q   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_left  <= '0;
      out_right <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            cap_l_q  <= in_left;
            cap_r_q  <= in_right;
            in_ready <= 1'b0;
            state_q  <= StRd;
          end
        end
        StRd: begin
          state_q <= StMix;
        end
        StMix: begin
          out_left  <= mix_l;
          out_right <= mix_r;
          out_valid <= 1'b1;
          if (ptr_last) begin
            wr_ptr_q <= '0;
            filled_q <= 1'b1;
          end else begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
          end
          state_q <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_echo.sv
// Directed bench for audio_echo with DEPTH=4, SHIFT=1; expected values are hand-computed.
module tb_audio_echo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_left = '0;
  logic [23:0] in_right = '0;
  logic        enable = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_left;
  logic [23:0] out_right;

  int n_total = 0;
  int n_bad   = 0;

  audio_echo #(
    .DATA_W(24),
    .DEPTH (4),
    .ADDR_W(2),
    .SHIFT (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_left  (in_left),
    .in_right (in_right),
    .enable   (enable),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_left (out_left),
    .out_right(out_right)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%06h exp=0x%06h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      in_left  = 24'($urandom);
      in_right = 24'($urandom);
      enable   = 1'($urandom);
      @(posedge clk);
      #1;
    end
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_left", 32'(out_left), 32'd0);
    check("rst_out_right", 32'(out_right), 32'd0);
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;
    enable   = 1'b1;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One full transaction with out_ready=1: handshake, latency check, data check, drain.
  task automatic xfer(input string tag, input logic [23:0] l, input logic [23:0] r,
                      input logic en, input logic [23:0] exp_l, input logic [23:0] exp_r);
    int n;
    in_left  = l;
    in_right = r;
    enable   = en;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd2);
    check({tag, "_l"}, 32'(out_left), 32'(exp_l));
    check({tag, "_r"}, 32'(out_right), 32'(exp_r));
    @(posedge clk);
    #1;
  endtask

  logic [23:0] exp_imp [9];
  logic [23:0] exp_rl  [9];
  logic [23:0] exp_rr  [9];

  initial begin
    exp_imp = '{24'h100000, 0, 0, 0, 24'h080000, 0, 0, 0, 0};
    exp_rl  = '{1, 2, 3, 4, 5, 7, 8, 10, 11};
    exp_rr  = '{2, 4, 6, 8, 11, 14, 17, 20, 23};

    do_reset();

    // Impulse
    for (int i = 0; i < 9; i++) begin
      xfer($sformatf("imp%0d", i), (i == 0) ? 24'h100000 : 24'h0, 24'h0, 1'b1, exp_imp[i], 24'h0);
    end

    // Positive and negative saturation, then a small negative echo
    do_reset();
    for (int i = 0; i < 5; i++) begin
      xfer($sformatf("satp%0d", i), 24'h7FFFFF, 24'h7FFFFF, 1'b1, 24'h7FFFFF, 24'h7FFFFF);
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      xfer($sformatf("satn%0d", i), 24'h800000, 24'h800000, 1'b1, 24'h800000, 24'h800000);
    end
    do_reset();
    xfer("neg0", 24'hFFFFFE, 24'h0, 1'b1, 24'hFFFFFE, 24'h0);
    for (int i = 1; i < 4; i++) begin
      xfer($sformatf("neg%0d", i), 24'h0, 24'h0, 1'b1, 24'h0, 24'h0);
    end
    xfer("neg4", 24'h0, 24'h0, 1'b1, 24'hFFFFFF, 24'h0);

    // Wrap and ramp; right channel ramps at twice the rate
    do_reset();
    for (int i = 0; i < 9; i++) begin
      xfer($sformatf("ramp%0d", i), 24'(i + 1), 24'(2 * (i + 1)), 1'b1, exp_rl[i], exp_rr[i]);
    end
    check("ramp_wr_ptr", 32'(dut.wr_ptr_q), 32'd1);

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    in_left   = 24'h000123;
    in_right  = 24'h000321;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_left  = 24'h000456;
    in_right = 24'h000654;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
    end
    check("bp_valid_rise", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_l%0d", i), 32'(out_left), 32'h000123);
      check($sformatf("bp_hold_rdy%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("bp_hold_v%0d", i), 32'(out_valid), 32'd1);
    end
    check("bp_hold_r", 32'(out_right), 32'h000321);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_drain_valid", 32'(out_valid), 32'd0);
    check("bp_drain_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_acc", 32'(in_ready), 32'd0);
    check("bp_next_k0", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp_next_k1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp_next_k2", 32'(out_valid), 32'd1);
    check("bp_next_l", 32'(out_left), 32'h000456);
    check("bp_next_r", 32'(out_right), 32'h000654);
    @(posedge clk);
    #1;

    // Reset asserted while in RD
    do_reset();
    in_left  = 24'h000055;
    in_right = 24'h000066;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_no_stale", 32'(out_valid), 32'd0);
    check("mid_ptr", 32'(dut.wr_ptr_q), 32'd0);
    xfer("mid0", 24'h000010, 24'h0, 1'b0, 24'h000010, 24'h0);
    for (int i = 1; i < 4; i++) begin
      xfer($sformatf("mid%0d", i), 24'h0, 24'h0, 1'b1, 24'h0, 24'h0);
    end
    xfer("mid4", 24'h0, 24'h0, 1'b1, 24'h000008, 24'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/audio_echo.md
# audio_echo

Stereo feed-forward echo stage that sits directly downstream of the codec read port and upstream of the moving-average output path. It accepts one left/right sample pair per handshake and stores it in a circular delay buffer. Each output equals the current input plus an attenuated copy of the input from DEPTH samples earlier, saturated to 24-bit signed.

## Interface
- DATA_W, 24: sample width, two's-complement signed.
- DEPTH, 4800: echo delay in accepted samples (0.1 s at 48 kHz); valid range 2..8192.
- ADDR_W, 13: buffer address width; must satisfy 2^ADDR_W >= DEPTH.
- SHIFT, 1: echo attenuation as an arithmetic right shift (1 gives half amplitude).
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample pair present.
- in_ready  out  1  stage can accept an input pair.
- in_left, in_right  in  DATA_W  input samples.
- enable  in  1  1 selects echo; 0 selects pass-through.
- out_valid  out  1  output pair present.
- out_ready  in  1  consumer accepts the output pair.
- out_left, out_right  out  DATA_W  output samples.

## Operation
- Buffer: two DEPTH x DATA_W synchronous-read RAMs (left and right), sharing one write pointer wr_ptr with range 0..DEPTH-1. Contents are not reset.
- filled flag: reset 0. Set when wr_ptr wraps from DEPTH-1 to 0. While 0, the delayed sample is treated as 0.
- FSM states: IDLE, RD, MIX, OUT. Reset state is IDLE.
  - IDLE: in_ready=1. When in_valid=1, capture in_left/in_right, present read address wr_ptr, and go to RD.
  - RD: wait for RAM data, then go to MIX.
  - MIX: compute the result and load the output registers. Write the captured inputs to the RAMs at wr_ptr. Advance wr_ptr (DEPTH-1 wraps to 0). Set out_valid. Go to OUT.
  - OUT: hold out_valid and out data stable. When out_ready=1, clear out_valid and go to IDLE.
- Because the read at wr_ptr happens before the write at wr_ptr, the delayed sample is exactly the input accepted DEPTH handshakes earlier.
- Arithmetic, per channel:
  - d = filled ? ram_q : 0.
  - e = d >>> SHIFT (sign-preserving shift).
  - s = sext(in) + sext(e), computed at DATA_W+1 bits.
  - If s > 0x7FFFFF, output 0x7FFFFF. If s < -0x800000, output 0x800000. Otherwise output s[DATA_W-1:0].
- enable is sampled in MIX. When enable=0, the output equals the captured input exactly. The buffer is still written and the pointer still advances.
- Left and right channels are fully independent, with identical pointer and timing.

## Timing
- Reset values: in_ready=1, out_valid=0, out_left=out_right=0, wr_ptr=0, filled=0, state IDLE. Reset applies asynchronously at any state.
- Reset asserted mid-operation drops the pending sample and writes nothing to the buffer after reset assertion.
- Input handshake at edge k (in_valid & in_ready): in_ready is 0 from edge k. out_valid=1 and data are valid after edge k+2.
- Output handshake at edge m (out_valid & out_ready): out_valid=0 and in_ready=1 after edge m. The next input can be accepted at edge m+1.
- Minimum period is 4 cycles per sample pair, far below the 1042-cycle codec period.
- in_valid asserted while in_ready=0 is ignored; the upstream holds its data.
- Output data is stable for the entire time out_valid=1.
- enable and in_* may change at any time; only values sampled at the defined edges matter.

## Test plan
Test configuration: DEPTH=4, SHIFT=1, ADDR_W=2, out_ready=1 unless stated otherwise.
- Reset: hold rst_n=0 for 5 cycles with random inputs -> in_ready=1, out_valid=0, outputs 0x000000.
- Impulse: input left 0x100000, then 8 zeros -> left outputs 0x100000, 0, 0, 0, 0x080000, 0, 0, 0, 0. Right stays 0.
- Saturation: five pairs of 0x7FFFFF -> fifth output 0x7FFFFF. Five pairs of 0x800000 -> fifth output 0x800000. Negative echo: input 0xFFFFFE, then 3 zeros, then 0 -> fifth output 0xFFFFFF.
- Wrap and ramp: inputs 1..9 -> outputs 1, 2, 3, 4, then 5+0=5, 6+1=7, 7+1=8, 8+2=10, 9+2=11. wr_ptr returns to 1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises, with in_valid=1 -> output stable, in_ready=0, no second sample accepted. Output handshake completes 1 cycle after out_ready rises. The next sample is then accepted and its latency is checked as edge k+2.
- Mid-operation: assert rst_n=0 in RD, then release. Then input 0x000010 with enable=0, followed by 4 zeros with enable=1 -> no stale output. Outputs are 0x000010, 0, 0, 0, 0x000008.
